// File: rtl/shift_rotate_pipe.sv
// shift_rotate_pipe: fully pipelined barrel shifter / rotator.
// Stage 0 turns every operation into one right shift of a widened source
// vector. Stages 1..SW each apply one power-of-two step of that shift.
// A single advance signal stalls the whole pipe when the output is blocked.
module shift_rotate_pipe #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH),
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_amt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);

  localparam int SRC_W = 2 * WIDTH - 1;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b100;
  localparam logic [2:0] OP_ROR = 3'b101;

  logic             advance;
  logic [SRC_W-1:0] src_next;
  logic [SRC_W-1:0] src_reg;
  logic [SW-1:0]    r_next;
  logic [SW-1:0]    r_reg;
  logic [SW-1:0]    amt_neg;
  logic             valid0_reg;
  logic [TAG_W-1:0] tag0_reg;
  logic             zero_reg;

  // The whole pipe moves together unless a result is waiting and not taken.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // (WIDTH - amt) mod WIDTH is just the two's complement in SW bits.
  assign amt_neg = SW'(0) - in_amt;

  // Map each op to a widened source and an equivalent right-shift amount.
  always_comb begin
    src_next = {{(WIDTH-1){1'b0}}, in_data};
    r_next   = '0;
    case (in_op)
      OP_SLL: begin
        // amt=0 keeps the plain source so the result is the operand itself.
        if (in_amt != '0) begin
          src_next = {in_data[WIDTH-2:0], {WIDTH{1'b0}}};
          r_next   = amt_neg;
        end
      end
      OP_SRL: r_next = in_amt;
      OP_SRA: begin
        src_next = {{(WIDTH-1){in_data[WIDTH-1]}}, in_data};
        r_next   = in_amt;
      end
      OP_ROL: begin
        src_next = {in_data[WIDTH-2:0], in_data};
        r_next   = amt_neg;
      end
      OP_ROR: begin
        src_next = {in_data[WIDTH-2:0], in_data};
        r_next   = in_amt;
      end
      default: ; // reserved ops fall through as a zero-distance shift
    endcase
    // Bubbles carry an all-zero payload so stale inputs never reach out_data.
    if (!in_valid) begin
      src_next = '0;
    end
  end

  // Stage 0: capture the pre-computed source, shift amount, tag and valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid0_reg <= 1'b0;
      src_reg    <= '0;
      r_reg      <= '0;
      tag0_reg   <= '0;
    end else if (advance) begin
      valid0_reg <= in_valid;
      src_reg    <= src_next;
      r_reg      <= r_next;
      tag0_reg   <= in_valid ? in_tag : '0;
    end
  end

  genvar gi;
  generate
    for (gi = 1; gi <= SW; gi++) begin : g_stage
      // Stage gi shifts by S and drops the S top bits no longer reachable.
      localparam int S  = 1 << (SW - gi);
      localparam int OW = WIDTH + S - 1;

      logic [OW+S-1:0]  data_in;
      logic [SW-gi:0]   r_in;
      logic             valid_in;
      logic [TAG_W-1:0] tag_in;
      logic [OW-1:0]    data_next;
      logic [OW-1:0]    data_reg;
      logic             valid_reg;
      logic [TAG_W-1:0] tag_reg;

      if (gi == 1) begin : g_src
        assign data_in  = src_reg;
        assign r_in     = r_reg;
        assign valid_in = valid0_reg;
        assign tag_in   = tag0_reg;
      end else begin : g_src
        assign data_in  = g_stage[gi-1].data_reg;
        assign r_in     = g_stage[gi-1].g_rem.rem_reg;
        assign valid_in = g_stage[gi-1].valid_reg;
        assign tag_in   = g_stage[gi-1].tag_reg;
      end

      // The MSB of the remaining amount selects this stage's shift step.
      assign data_next = r_in[SW-gi] ? data_in[OW+S-1:S] : data_in[OW-1:0];

      // Register the narrowed vector together with its valid and tag.
      always_ff @(posedge clock) begin
        if (reset) begin
          valid_reg <= 1'b0;
          tag_reg   <= '0;
          data_reg  <= '0;
        end else if (advance) begin
          valid_reg <= valid_in;
          tag_reg   <= tag_in;
          data_reg  <= data_next;
        end
      end

      if (gi < SW) begin : g_rem
        logic [SW-gi-1:0] rem_reg;

        // Forward only the amount bits that later stages still consume.
        always_ff @(posedge clock) begin
          if (reset) begin
            rem_reg <= '0;
          end else if (advance) begin
            rem_reg <= r_in[SW-gi-1:0];
          end
        end
      end
    end
  endgenerate

  // Zero flag is registered alongside the final data, not derived from it.
  always_ff @(posedge clock) begin
    if (reset) begin
      zero_reg <= 1'b0;
    end else if (advance) begin
      zero_reg <= (g_stage[SW].data_next == '0);
    end
  end

  assign out_valid = g_stage[SW].valid_reg;
  assign out_data  = g_stage[SW].data_reg;
  assign out_tag   = g_stage[SW].tag_reg;
  assign out_zero  = zero_reg;

endmodule
